// File: rtl/registrador_historico_pkg.sv
// rtl/registrador_historico_pkg.sv - derived widths shared by the history register and its entries
package registrador_historico_pkg;

    localparam int DEPTH_DEFAULT = 8;
    localparam int IDX_W         = $clog2(DEPTH_DEFAULT);
    localparam int CNT_W         = IDX_W + 1;

    function automatic int idx_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int cnt_w(input int depth);
        return idx_w(depth) + 1;
    endfunction

    // Running sum must hold DEPTH full-scale samples without overflow.
    function automatic int sum_w(input int width, input int depth);
        return width + idx_w(depth);
    endfunction

endpackage

// File: rtl/registrador_n.sv
// rtl/registrador_n.sv - WIDTH-bit storage register with synchronous reset, clear and enable
module registrador_n #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clear) begin
            q_d = '0;
        end else if (enable) begin
            q_d = d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/registrador_historico.sv
// rtl/registrador_historico.sv - circular sample history with age-indexed readback
// Optional running average compiled in with REGISTRADOR_HISTORICO_AVG_EN.
module registrador_historico
    import registrador_historico_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      enable,
    input  logic [WIDTH-1:0]          D,
    input  logic [idx_w(DEPTH)-1:0]   rd_idx,
    output logic [WIDTH-1:0]          Q,
    output logic [WIDTH-1:0]          rd_data,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      full,
    output logic [WIDTH-1:0]          avg,
    output logic                      avg_valid
);

    localparam int IDX_BITS = idx_w(DEPTH);
    localparam int CNT_BITS = cnt_w(DEPTH);
    localparam logic [CNT_BITS-1:0] DEPTH_CNT = CNT_BITS'(DEPTH);

    logic [IDX_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_BITS-1:0] count_q, count_d;
    logic [WIDTH-1:0]    q_q, q_d;
    logic                wr_en;
    logic                full_w;
    logic [DEPTH-1:0]    entry_we;
    logic [IDX_BITS-1:0] rd_ptr;
    logic [WIDTH-1:0]    entry [DEPTH];

    // Clear beats a simultaneous write; reset is applied inside each flop.
    always_comb begin
        wr_en  = enable & ~clear;
        full_w = (count_q == DEPTH_CNT);
        for (int i = 0; i < DEPTH; i++) begin
            entry_we[i] = wr_en && (wr_ptr_q == IDX_BITS'(i));
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        q_d      = q_q;
        if (clear) begin
            wr_ptr_d = '0;
            count_d  = '0;
            q_d      = '0;
        end else if (enable) begin
            wr_ptr_d = wr_ptr_q + IDX_BITS'(1);
            q_d      = D;
            if (!full_w) begin
                count_d = count_q + CNT_BITS'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
            q_q      <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            q_q      <= q_d;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        registrador_n #(
            .WIDTH (WIDTH)
        ) u_entry (
            .clock  (clock),
            .reset  (reset),
            .clear  (clear),
            .enable (entry_we[g]),
            .d      (D),
            .q      (entry[g])
        );
    end

    // Age 0 sits just behind the write pointer; ages not yet written read as zero.
    always_comb begin
        rd_ptr  = wr_ptr_q - IDX_BITS'(1) - rd_idx;
        rd_data = ({1'b0, rd_idx} < count_q) ? entry[rd_ptr] : '0;
    end

    assign Q     = q_q;
    assign count = count_q;
    assign full  = full_w;

`ifdef REGISTRADOR_HISTORICO_AVG_EN
    localparam int SUM_BITS = sum_w(WIDTH, DEPTH);

    logic [SUM_BITS-1:0] sum_q, sum_d;
    logic [SUM_BITS-1:0] evict;
    logic [WIDTH-1:0]    avg_q, avg_d;

    // When full, the slot about to be overwritten holds the oldest sample.
    always_comb begin
        evict = full_w ? SUM_BITS'(entry[wr_ptr_q]) : '0;
        sum_d = sum_q;
        avg_d = avg_q;
        if (clear) begin
            sum_d = '0;
            avg_d = '0;
        end else if (enable) begin
            sum_d = sum_q + SUM_BITS'(D) - evict;
            avg_d = sum_d[SUM_BITS-1:IDX_BITS];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sum_q <= '0;
            avg_q <= '0;
        end else begin
            sum_q <= sum_d;
            avg_q <= avg_d;
        end
    end

    assign avg       = avg_q;
    assign avg_valid = full_w;
`else
    assign avg       = '0;
    assign avg_valid = 1'b0;
`endif

endmodule

// File: tb/tb_registrador_historico.sv
// tb/tb_registrador_historico.sv - randomized self-checking bench against a queue model of the history
module tb_registrador_historico;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;

    logic             clock;
    logic             reset;
    logic             clear;
    logic             enable;
    logic [WIDTH-1:0] D;
    logic [2:0]       rd_idx;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] rd_data;
    logic [3:0]       count;
    logic             full;
    logic [WIDTH-1:0] avg;
    logic             avg_valid;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: newest sample at the front of the queue.
    int unsigned      hist[$];
    logic [WIDTH-1:0] m_q;

    registrador_historico #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .clear     (clear),
        .enable    (enable),
        .D         (D),
        .rd_idx    (rd_idx),
        .Q         (Q),
        .rd_data   (rd_data),
        .count     (count),
        .full      (full),
        .avg       (avg),
        .avg_valid (avg_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [WIDTH-1:0] m_rd(input int idx);
        return (idx < hist.size()) ? WIDTH'(hist[idx]) : '0;
    endfunction

    function automatic logic [WIDTH-1:0] m_avg();
        int unsigned s;
        s = 0;
`ifdef REGISTRADOR_HISTORICO_AVG_EN
        foreach (hist[i]) s += hist[i];
        s = s / DEPTH;
`endif
        return WIDTH'(s);
    endfunction

    function automatic logic m_avg_valid();
`ifdef REGISTRADOR_HISTORICO_AVG_EN
        return hist.size() == DEPTH;
`else
        return 1'b0;
`endif
    endfunction

    task automatic step(input logic rst, input logic clr, input logic en, input logic [WIDTH-1:0] d);
        @(negedge clock);
        reset  = rst;
        clear  = clr;
        enable = en;
        D      = d;
        @(posedge clock);
        #1;
        if (rst || clr) begin
            hist.delete();
            m_q = '0;
        end else if (en) begin
            hist.push_front(int'(d));
            if (hist.size() > DEPTH) void'(hist.pop_back());
            m_q = d;
        end
        reset  = 1'b0;
        clear  = 1'b0;
        enable = 1'b0;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b1, 8'h5A);
        n_cmp++; if (Q !== 8'd0) begin n_fail++; $display("FAIL reset_q got %0d want 0", Q); end
        n_cmp++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %0b want 0", full); end
        n_cmp++; if (avg !== 8'd0) begin n_fail++; $display("FAIL reset_avg got %0d want 0", avg); end
        n_cmp++; if (avg_valid !== 1'b0) begin n_fail++; $display("FAIL reset_avg_valid got %0b want 0", avg_valid); end
        for (int i = 0; i < DEPTH; i++) begin
            rd_idx = 3'(i); #1;
            n_cmp++; if (rd_data !== 8'd0) begin n_fail++; $display("FAIL reset_rd idx %0d got %0d want 0", i, rd_data); end
        end
    endtask

    task automatic test_basic();
        int exp_r[4];
        exp_r = '{3, 9, 5, 0};
        step(1'b1, 1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b0, 1'b1, 8'd5);
        step(1'b0, 1'b0, 1'b1, 8'd9);
        step(1'b0, 1'b0, 1'b1, 8'd3);
        n_cmp++; if (Q !== 8'd3) begin n_fail++; $display("FAIL basic_q got %0d want 3", Q); end
        n_cmp++; if (count !== 4'd3) begin n_fail++; $display("FAIL basic_count got %0d want 3", count); end
        n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL basic_full got %0b want 0", full); end
        for (int i = 0; i < 4; i++) begin
            rd_idx = 3'(i); #1;
            n_cmp++; if (rd_data !== 8'(exp_r[i])) begin n_fail++; $display("FAIL basic_rd idx %0d got %0d want %0d", i, rd_data, exp_r[i]); end
        end
    endtask

    task automatic test_wrap();
        step(1'b1, 1'b0, 1'b0, 8'd0);
        for (int i = 1; i <= 8; i++) step(1'b0, 1'b0, 1'b1, 8'(i));
        n_cmp++; if (full !== 1'b1) begin n_fail++; $display("FAIL wrap_full got %0b want 1", full); end
        n_cmp++; if (count !== 4'd8) begin n_fail++; $display("FAIL wrap_count got %0d want 8", count); end
        step(1'b0, 1'b0, 1'b1, 8'd9);
        rd_idx = 3'd7; #1;
        n_cmp++; if (rd_data !== 8'd2) begin n_fail++; $display("FAIL wrap_oldest got %0d want 2", rd_data); end
        rd_idx = 3'd0; #1;
        n_cmp++; if (rd_data !== 8'd9) begin n_fail++; $display("FAIL wrap_newest got %0d want 9", rd_data); end
        n_cmp++; if (count !== 4'd8) begin n_fail++; $display("FAIL wrap_count_sat got %0d want 8", count); end
        n_cmp++; if (full !== 1'b1) begin n_fail++; $display("FAIL wrap_full_hold got %0b want 1", full); end
    endtask

    task automatic test_avg();
        step(1'b1, 1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 8'd16);
`ifdef REGISTRADOR_HISTORICO_AVG_EN
        n_cmp++; if (avg !== 8'd16) begin n_fail++; $display("FAIL avg_full got %0d want 16", avg); end
        n_cmp++; if (avg_valid !== 1'b1) begin n_fail++; $display("FAIL avg_valid got %0b want 1", avg_valid); end
        step(1'b0, 1'b0, 1'b1, 8'd24);
        n_cmp++; if (avg !== 8'd17) begin n_fail++; $display("FAIL avg_slide got %0d want 17", avg); end
`else
        n_cmp++; if (avg !== 8'd0) begin n_fail++; $display("FAIL avg_off got %0d want 0", avg); end
        n_cmp++; if (avg_valid !== 1'b0) begin n_fail++; $display("FAIL avg_valid_off got %0b want 0", avg_valid); end
`endif
    endtask

    task automatic test_clear_priority();
        step(1'b0, 1'b0, 1'b1, 8'd44);
        step(1'b0, 1'b1, 1'b1, 8'hAA);
        n_cmp++; if (count !== 4'd0) begin n_fail++; $display("FAIL clear_count got %0d want 0", count); end
        n_cmp++; if (Q !== 8'd0) begin n_fail++; $display("FAIL clear_q got %0d want 0", Q); end
        n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL clear_full got %0b want 0", full); end
        for (int i = 0; i < DEPTH; i++) begin
            rd_idx = 3'(i); #1;
            n_cmp++; if (rd_data !== 8'd0) begin n_fail++; $display("FAIL clear_rd idx %0d got %0d want 0", i, rd_data); end
        end
    endtask

    task automatic test_hold();
        logic [WIDTH-1:0] snap_q;
        int               snap_n;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 8'($urandom));
        snap_q = m_q;
        snap_n = hist.size();
        for (int c = 0; c < 10; c++) begin
            step(1'b0, 1'b0, 1'b0, (c % 2 == 0) ? 8'hFF : 8'h00);
            n_cmp++; if (Q !== snap_q) begin n_fail++; $display("FAIL hold_q cyc %0d got %0d want %0d", c, Q, snap_q); end
            n_cmp++; if (count !== 4'(snap_n)) begin n_fail++; $display("FAIL hold_count cyc %0d got %0d want %0d", c, count, snap_n); end
            rd_idx = 3'(c % DEPTH); #1;
            n_cmp++; if (rd_data !== m_rd(c % DEPTH)) begin n_fail++; $display("FAIL hold_rd idx %0d got %0d want %0d", c % DEPTH, rd_data, m_rd(c % DEPTH)); end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 8'($urandom_range(1, 255)));
        step(1'b1, 1'b0, 1'b0, 8'd0);
        n_cmp++; if (Q !== 8'd0) begin n_fail++; $display("FAIL mid_reset_q got %0d want 0", Q); end
        n_cmp++; if (count !== 4'd0) begin n_fail++; $display("FAIL mid_reset_count got %0d want 0", count); end
        n_cmp++; if (avg !== 8'd0) begin n_fail++; $display("FAIL mid_reset_avg got %0d want 0", avg); end
        rd_idx = 3'd0; #1;
        n_cmp++; if (rd_data !== 8'd0) begin n_fail++; $display("FAIL mid_reset_rd got %0d want 0", rd_data); end
        step(1'b0, 1'b0, 1'b1, 8'd7);
        n_cmp++; if (count !== 4'd1) begin n_fail++; $display("FAIL mid_reset_count1 got %0d want 1", count); end
        n_cmp++; if (Q !== 8'd7) begin n_fail++; $display("FAIL mid_reset_q7 got %0d want 7", Q); end
    endtask

    task automatic test_random();
        logic rst, clr, en;
        int   idx;
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 49) == 0);
            clr = ($urandom_range(0, 39) == 0);
            en  = ($urandom_range(0, 3) != 0);
            step(rst, clr, en, 8'($urandom));
            idx = $urandom_range(0, DEPTH - 1);
            rd_idx = 3'(idx); #1;
            n_cmp++; if (Q !== m_q) begin n_fail++; $display("FAIL rand_q cyc %0d got %0d want %0d", c, Q, m_q); end
            n_cmp++; if (count !== 4'(hist.size())) begin n_fail++; $display("FAIL rand_count cyc %0d got %0d want %0d", c, count, hist.size()); end
            n_cmp++; if (full !== (hist.size() == DEPTH)) begin n_fail++; $display("FAIL rand_full cyc %0d got %0b", c, full); end
            n_cmp++; if (rd_data !== m_rd(idx)) begin n_fail++; $display("FAIL rand_rd cyc %0d idx %0d got %0d want %0d", c, idx, rd_data, m_rd(idx)); end
            n_cmp++; if (avg !== m_avg()) begin n_fail++; $display("FAIL rand_avg cyc %0d got %0d want %0d", c, avg, m_avg()); end
            n_cmp++; if (avg_valid !== m_avg_valid()) begin n_fail++; $display("FAIL rand_avg_valid cyc %0d got %0b want %0b", c, avg_valid, m_avg_valid()); end
        end
    endtask

    initial begin
        reset  = 1'b1;
        clear  = 1'b0;
        enable = 1'b0;
        D      = '0;
        rd_idx = '0;
        m_q    = '0;
        test_reset();
        test_basic();
        test_wrap();
        test_avg();
        test_clear_priority();
        test_hold();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/registrador_historico.md
REGISTRADOR_HISTORICO -- requirements
Module: registrador_historico

Interface
REQ-001 Parameter WIDTH, default 8: bit width of each stored sample.
REQ-002 Parameter DEPTH, default 8: number of samples kept; SHALL be a power of two, at least 2.
REQ-003 clock  input  1: single clock; all state changes on its rising edge.
REQ-004 reset  input  1: synchronous, active-high reset.
REQ-005 clear  input  1: synchronous, active-high clear of the history, same effect as reset.
REQ-006 enable  input  1: when high at a rising edge, D is written as the newest sample.
REQ-007 D  input  WIDTH: sample to store.
REQ-008 rd_idx  input  log2(DEPTH): age of the sample to read; 0 is the newest.
REQ-009 Q  output  WIDTH: newest stored sample, registered.
REQ-010 rd_data  output  WIDTH: sample of age rd_idx, combinational from stored state and rd_idx.
REQ-011 count  output  log2(DEPTH)+1: number of valid samples, 0..DEPTH.
REQ-012 full  output  1: high when count equals DEPTH.
REQ-013 avg  output  WIDTH: mean of the stored window (AVG_EN builds only).
REQ-014 avg_valid  output  1: high when avg covers a full window (AVG_EN builds only).

Function
REQ-015 Write: enable high at an edge stores D at wr_ptr, advances wr_ptr modulo DEPTH and loads Q with D, so Q equals D one edge later.
REQ-016 count increments by 1 per write and saturates at DEPTH.
REQ-017 Full and enable high: the oldest sample is overwritten (circular), count stays DEPTH, full stays high.
REQ-018 enable low: all storage, wr_ptr, count, Q and avg hold.
REQ-019 rd_data returns the sample written rd_idx writes before the newest, i.e. entry (wr_ptr-1-rd_idx) mod DEPTH.
REQ-020 rd_data SHALL be 0 when rd_idx >= count (unwritten age).
REQ-021 clear and enable both high at one edge: clear wins and D is discarded.
REQ-022 No other event, including overflow, produces X or an error state; there are no error outputs.

Reset
REQ-023 reset high at an edge: every entry, wr_ptr, count, Q, the running sum and avg go to 0; full and avg_valid go low.
REQ-024 reset asserted mid-stream discards all history; the first write after it yields count=1.
REQ-025 reset takes priority over clear and enable.

Configuration
REQ-026 Macro REGISTRADOR_HISTORICO_AVG_EN compiles in the running-average logic.
REQ-027 With the macro: a running sum of width WIDTH+log2(DEPTH) updates each write as sum + D minus the evicted sample when full, or plus 0 when not full.
REQ-028 With the macro: avg is sum shifted right by log2(DEPTH) and is registered with the write; avg_valid equals full.
REQ-029 Without the macro: avg and avg_valid are driven constant 0 and no sum register exists.

Structure
REQ-030 A shared package holds the derived constants IDX_W=log2(DEPTH) and CNT_W=IDX_W+1, plus the sum-width function.
REQ-031 Each storage entry is one instance of sub-module registrador_n, a WIDTH-bit register with synchronous clear and enable. The write decoder drives its enables.
REQ-032 wr_ptr/count control and the averaging path stay in the top module.

Verification
REQ-033 Reset, then write 5, 9, 3 -> Q=3, count=3, rd_idx 0/1/2 give 3/9/5, rd_idx 3 gives 0, full=0.
REQ-034 DEPTH=8: write 1..8 -> full=1, count=8; write 9 -> rd_idx 7 gives 2, rd_idx 0 gives 9, count=8.
REQ-035 AVG_EN, DEPTH=8: write 8 samples of 16 -> avg=16, avg_valid=1; write 24 -> avg=17 (136/8).
REQ-036 clear and enable high with D=0xAA -> count=0, Q=0, rd_data=0 for all rd_idx.
REQ-037 enable low for 10 cycles with D toggling -> Q, count and rd_data unchanged.
REQ-038 reset pulse after 6 writes -> all outputs 0; next write of 7 -> count=1, Q=7.
